dsp_simd_pack: RTL
==================

DSP_SIMD_PACK -- requirements
Module: dsp_simd_pack

Interface
REQ-001 SHALL have parameter: width, 12, bits per lane operand.
REQ-002 SHALL have parameter: lanes, 4, lanes per packed group; width*lanes SHALL be <= 48, checked at elaboration.
REQ-003 SHALL have port: clock  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port: in_valid  in  1  scalar operand pair offered.
REQ-006 SHALL have port: in_ready  out  1  block can accept a pair this cycle.
REQ-007 SHALL have port: in_a  in  width  scalar operand A.
REQ-008 SHALL have port: in_b  in  width  scalar operand B.
REQ-009 SHALL have port: flush  in  1  close the partially filled group.
REQ-010 SHALL have port: out_valid  out  1  packed group available to the downstream dsp_add_v*/dsp_sub_v* stage.
REQ-011 SHALL have port: out_ready  in  1  downstream accepts the group.
REQ-012 SHALL have port: out_a  out  width*lanes  packed A operands, lane k at bits [k*width +: width].
REQ-013 SHALL have port: out_b  out  width*lanes  packed B operands, same lane layout.
REQ-014 SHALL have port: out_mask  out  lanes  bit k set = lane k holds a real operand.

Function
REQ-015 SHALL accept a pair on a rising edge with in_valid=1 and in_ready=1; the n-th accepted pair of a group goes to lane n (0-based) of the fill buffer.
REQ-016 SHALL keep a fill count 0..lanes and a two-state FSM: FILL (count < lanes, group open) and CLOSED (group complete, waiting for the output slot).
REQ-017 SHALL close a group when the accept fills lane lanes-1, or when flush=1 and at least one lane is filled, counting a same-cycle accept.
REQ-018 SHALL ignore flush when count=0 and no accept occurs that cycle.
REQ-019 SHALL treat the output slot as free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-020 SHALL load a closing group into the output register on the same edge when the slot is free; out_valid is then 1 from the next cycle, count returns to 0, and the FSM stays in FILL.
REQ-021 SHALL enter CLOSED when a closing group finds the slot busy; while in CLOSED, in_ready SHALL be 0.
REQ-022 SHALL transfer the CLOSED group to the output register on the edge where out_valid=1 and out_ready=1, then return to FILL with count 0; in_ready SHALL be 1 in the following cycle.
REQ-023 SHALL drive in_ready=1 in FILL regardless of out_ready, with no combinational path from out_ready to in_ready.
REQ-024 SHALL hold out_a, out_b and out_mask stable while out_valid=1 and out_ready=0.
REQ-025 SHALL zero the data bits of unfilled lanes, with the matching out_mask bits 0.
REQ-026 SHALL clear out_valid after a handshake unless a new group loads on the same edge.
REQ-027 SHALL pack operands bit-exact, with no sign extension, saturation or reordering.
REQ-028 SHALL have a minimum latency from the last accept of a group to out_valid=1 of one cycle.
REQ-029 SHALL sustain one accept per cycle and one group per lanes cycles when out_ready is held at 1.

Reset
REQ-030 SHALL, while reset=0 (asynchronously), force FSM=FILL, count=0, out_valid=0, out_a=0, out_b=0, out_mask=0, and in_ready=0.
REQ-031 SHALL drive in_ready=1 from the first rising edge after reset deasserts.
REQ-032 SHALL, on reset mid-group or while CLOSED, discard partial and pending groups with no output emitted.

Verification (width=12, lanes=4)
REQ-033 SHALL be verified by: 4 back-to-back pairs A=0xFFF,0x017,0x0FF,0xFEC and B=0x010,0x007,0x007,0xFF9, out_ready=1 -> one cycle later out_valid=1, out_a=0xFEC0FF017FFF, out_b=0xFF9007007010, out_mask=4'b1111.
REQ-034 SHALL be verified by: 2 pairs (0x001/0xFF0, 0xFE9/0xFF9), then flush=1 alone -> next cycle out_a=0x000000FE9001, out_b=0x000000FF9FF0, out_mask=4'b0011.
REQ-035 SHALL be verified by: out_ready=0, 8 pairs offered continuously -> first group on the output, in_ready=0 after the 8th accept; out_ready=1 for one cycle -> second group appears and in_ready=1 the following cycle, with no pair lost or duplicated.
REQ-036 SHALL be verified by: flush=1 with count=0 and in_valid=0 -> out_valid stays 0 and count stays 0.
REQ-037 SHALL be verified by: reset=0 pulsed after 3 accepts -> outputs are 0 immediately; after release, 4 new pairs produce a group containing only the new pairs.
REQ-038 SHALL be verified by: a 4-lane group fed into dsp_add_v4 -> each lane sum equals the scalar a+b mod 2^12.

Source files
------------

// File: rtl/dsp_simd_pack_if.sv
// Handshake bus for the scalar-to-SIMD operand packer: a scalar pair stream in,
// and packed lane groups with a valid-lane mask out.
interface dsp_simd_pack_if #(
  parameter int width = 12,
  parameter int lanes = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [width-1:0]         in_a;
  logic [width-1:0]         in_b;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [width*lanes-1:0]   out_a;
  logic [width*lanes-1:0]   out_b;
  logic [lanes-1:0]         out_mask;

  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_mask
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_mask
  );
endinterface

// File: rtl/dsp_simd_pack.sv
// Packs a stream of scalar operand pairs into lane groups for the vector
// add/sub stages; a group closes when full or on flush, and waits if the output slot is busy.
module dsp_simd_pack #(
  parameter int width = 12,
  parameter int lanes = 4
) (
  input  logic          clock,
  input  logic          reset,
  dsp_simd_pack_if.slave bus
);

  localparam int CW = $clog2(lanes + 1);
  localparam int PW = width * lanes;
  localparam logic [CW-1:0] LAST = CW'(lanes - 1);

  if (PW > 48) begin : g_width_check
    $error("dsp_simd_pack: width*lanes must not exceed 48");
  end

  typedef enum logic {FILL, CLOSED} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_add;
  logic             rdy_q;
  logic             vld_q;
  logic [PW-1:0]    buf_a_q, buf_b_q;
  logic [PW-1:0]    ins_a, ins_b;
  logic [PW-1:0]    grp_a, grp_b;
  logic [lanes-1:0] grp_mask;
  logic [PW-1:0]    out_a_q, out_b_q;
  logic [lanes-1:0] out_mask_q;
  logic             acc, slot_free, closing, load_out;

  function automatic logic [lanes-1:0] fill_mask(input logic [CW-1:0] n);
    logic [lanes-1:0] m;
    for (int k = 0; k < lanes; k++) m[k] = (CW'(k) < n);
    return m;
  endfunction

  function automatic logic [PW-1:0] gate_lanes(input logic [PW-1:0] v,
                                               input logic [lanes-1:0] m);
    logic [PW-1:0] r;
    r = v;
    for (int k = 0; k < lanes; k++)
      if (!m[k]) r[k*width +: width] = '0;
    return r;
  endfunction

  assign bus.in_ready  = rdy_q && (state_q == FILL);
  assign bus.out_valid = vld_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_mask  = out_mask_q;

  assign acc       = bus.in_valid && bus.in_ready;
  assign cnt_add   = cnt_q + CW'(acc);
  assign slot_free = !vld_q || bus.out_ready;
  assign closing   = (state_q == FILL) &&
                     ((acc && cnt_q == LAST) || (bus.flush && cnt_add != '0));
  assign load_out  = (state_q == FILL) ? (closing && slot_free)
                                       : (vld_q && bus.out_ready);

  // Group assembly: fill buffer plus any same-cycle accept, unfilled lanes zeroed.
  always_comb begin
    ins_a = buf_a_q;
    ins_b = buf_b_q;
    for (int k = 0; k < lanes; k++) begin
      if (acc && cnt_q == CW'(k)) begin
        ins_a[k*width +: width] = bus.in_a;
        ins_b[k*width +: width] = bus.in_b;
      end
    end
    grp_mask = fill_mask(cnt_add);
    grp_a    = gate_lanes(ins_a, grp_mask);
    grp_b    = gate_lanes(ins_b, grp_mask);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (closing && !slot_free) state_d = CLOSED;
      CLOSED:  if (vld_q && bus.out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_mask_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (load_out)  cnt_q <= '0;
      else if (acc)  cnt_q <= cnt_add;
      // Output slot: load a closing or pending group, else drop after handshake.
      if (load_out) begin
        vld_q      <= 1'b1;
        out_a_q    <= grp_a;
        out_b_q    <= grp_b;
        out_mask_q <= grp_mask;
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  // Stale lanes beyond the count are masked at load, so the buffer needs no reset.
  always_ff @(posedge clock) begin
    if (acc) begin
      buf_a_q <= ins_a;
      buf_b_q <= ins_b;
    end
  end

endmodule
